// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: slave end of the core's dreq/dresp data bus.
// One request in flight at a time, completed LATENCY cycles after capture
// against a 64-bit-word SRAM. Illegal requests still complete, but with
// data=0, no write, and the sticky err flag set.
module dbus_sram_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        err
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_addr;
  logic [2:0]  r_size;
  logic [7:0]  r_strobe;
  logic [63:0] r_data;
  logic        r_data_ok;
  logic [63:0] r_rdata;
  logic        r_err;

  logic [63:0] r_mem [DEPTH];

  // With LATENCY=1 the DONE edge follows the capture cycle directly, so the
  // request being acted on comes straight from the bus while IDLE.
  logic          w_idle;
  logic [63:0]   w_cur_addr;
  logic [2:0]    w_cur_size;
  logic [7:0]    w_cur_strobe;
  logic [63:0]   w_cur_data;
  logic [63:0]   w_off;
  logic          w_in_range;
  logic          w_aligned;
  logic          w_legal;
  logic [AW-1:0] w_idx;
  logic          w_enter_done;
  logic          w_mismatch;

  assign w_idle       = (r_state == S_IDLE);
  assign w_cur_addr   = w_idle ? dreq_addr   : r_addr;
  assign w_cur_size   = w_idle ? dreq_size   : r_size;
  assign w_cur_strobe = w_idle ? dreq_strobe : r_strobe;
  assign w_cur_data   = w_idle ? dreq_data   : r_data;

  assign w_off      = w_cur_addr - BASE_ADDR;
  assign w_in_range = (w_cur_addr >= BASE_ADDR) && (w_off < SPAN);
  assign w_idx      = w_off[AW+2:3];
  assign w_legal    = w_in_range && w_aligned;

  // Natural alignment per access size; sizes above 8B are not encodable
  // transfers and are treated as misaligned.
  always_comb begin
    w_aligned = 1'b0;
    case (w_cur_size)
      3'd0:    w_aligned = 1'b1;
      3'd1:    w_aligned = (w_cur_addr[0] == 1'b0);
      3'd2:    w_aligned = (w_cur_addr[1:0] == 2'b00);
      3'd3:    w_aligned = (w_cur_addr[2:0] == 3'b000);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_enter_done = !reset && dreq_valid &&
                        ((w_idle && LATENCY == 1) ||
                         (r_state == S_BUSY && r_cnt == 4'd1));

  assign w_mismatch = (dreq_addr != r_addr) || (dreq_size != r_size) ||
                      (dreq_strobe != r_strobe) || (dreq_data != r_data);

  // Control FSM, request capture, response and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= 64'd0;
      r_size    <= 3'd0;
      r_strobe  <= 8'd0;
      r_data    <= 64'd0;
      r_data_ok <= 1'b0;
      r_rdata   <= 64'd0;
      r_err     <= 1'b0;
    end else begin
      r_data_ok <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dreq_valid) begin
            r_addr   <= dreq_addr;
            r_size   <= dreq_size;
            r_strobe <= dreq_strobe;
            r_data   <= dreq_data;
            if (LATENCY == 1) begin
              r_state <= S_DONE;
            end else begin
              r_cnt   <= 4'(LATENCY - 1);
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (!dreq_valid) begin
            // Initiator flushed the request: drop it silently.
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            if (w_mismatch) r_err <= 1'b1;
            if (r_cnt == 4'd1) begin
              r_state <= S_DONE;
              r_cnt   <= 4'd0;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_enter_done) begin
        r_data_ok <= 1'b1;
        r_rdata   <= w_legal ? r_mem[w_idx] : 64'd0;
        if (!w_legal) r_err <= 1'b1;
      end
    end
  end

  // SRAM byte-strobed write on the DONE edge; contents survive reset
  always_ff @(posedge clk) begin
    if (w_enter_done && w_legal) begin
      for (int i = 0; i < 8; i++) begin
        if (w_cur_strobe[i]) r_mem[w_idx][8*i +: 8] <= w_cur_data[8*i +: 8];
      end
    end
  end

  assign dresp_addr_ok = w_idle && dreq_valid && !reset;
  assign dresp_data_ok = r_data_ok && !reset;
  assign dresp_data    = r_rdata;
  assign err           = r_err;

endmodule
